// File: rtl/mem_loader.sv
// mem_loader: bulk RAM write initiator. Packs a byte stream (valid/ready)
// into little-endian 32-bit words and writes them to consecutive RAM word
// addresses starting at a programmed base, wrapping modulo 2^ADDR_W.
//
// Handshake: a byte transfers on a rising edge where byteValid and
// byteReady are both high. byteReady is a registered Moore output (high
// only in COLLECT), so it never depends on byteValid in the same cycle.
module mem_loader #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [CNT_W-1:0]  wordCount,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memData,
  output logic              memWen,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wordsWritten,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;          // next RAM address to write
  logic [CNT_W-1:0]    count_q, count_d;        // latched word count
  logic [CNT_W-1:0]    words_q, words_d;        // words committed so far
  logic [1:0]          idx_q, idx_d;            // next byte lane
  logic [23:0]         word_q, word_d;          // lanes 0..2 of word in progress
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;  // held RAM address output
  logic [31:0]         mem_data_q, mem_data_d;  // held RAM data output
  logic                ready_q, ready_d;
  logic                wen_q, wen_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    words_inc;

  assign words_inc = words_q + 1'b1;

  // Next-state and datapath update for the IDLE/COLLECT/WRITE/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    words_d    = words_q;
    idx_d      = idx_q;
    word_d     = word_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          words_d = '0;
          idx_d   = '0;
          if (wordCount != '0) begin
            addr_d  = baseAddr;
            count_d = wordCount;
            state_d = S_COLLECT;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_COLLECT: begin
        if (abort) begin
          // Partial word is dropped; lanes are simply overwritten next time.
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (byteValid) begin
          unique case (idx_q)
            2'd0: word_d[7:0]   = byteIn;
            2'd1: word_d[15:8]  = byteIn;
            2'd2: word_d[23:16] = byteIn;
            2'd3: begin
              // Last lane goes straight into the output word register so the
              // write can be presented in the very next cycle.
              mem_data_d = {byteIn, word_q};
              mem_addr_d = addr_q;
              state_d    = S_WRITE;
            end
            default: ;
          endcase
          idx_d = idx_q + 2'd1;
        end
      end

      S_WRITE: begin
        // The write presented this cycle always completes, even on abort.
        addr_d  = addr_q + 1'b1;
        words_d = words_inc;
        idx_d   = '0;
        if (abort) begin
          state_d = S_IDLE;
        end else if (words_inc == count_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Moore outputs for the state being entered, so they come out of flops.
    ready_d = (state_d == S_COLLECT);
    wen_d   = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      words_q    <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      ready_q    <= 1'b0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      words_q    <= words_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      ready_q    <= ready_d;
      wen_q      <= wen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign byteReady    = ready_q;
  assign memWen       = wen_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign memAddr      = mem_addr_q;
  assign memData      = mem_data_q;
  assign wordsWritten = words_q;
  assign dbgState     = state_q;

endmodule
